// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control FSM (IF/ID/EXE/MEM/WB/TRAP) with memory wait-state handshake,
// bounded memory timeout and illegal-instruction trap. Outputs are decoded combinationally from state.
module mc_ctrl #(
  parameter int ALUCTR_W    = 5,
  parameter int MEM_TIMEOUT = 255,
  parameter int TMO_W       = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [5:0]          op,
  input  logic [5:0]          func,
  input  logic [4:0]          rt,
  input  logic                mem_ready,
  output logic                PCWr,
  output logic                PCWrCond,
  output logic                IRWr,
  output logic [1:0]          RegDst,
  output logic                RegWr,
  output logic                ALUSrc,
  output logic                MemRd,
  output logic                MemWr,
  output logic                IorD,
  output logic [1:0]          MemtoReg,
  output logic [1:0]          ExtOp,
  output logic [1:0]          MemSz,
  output logic [ALUCTR_W-1:0] ALUctr,
  output logic [2:0]          BrType,
  output logic [1:0]          Jump,
  output logic [2:0]          state,
  output logic [1:0]          cause
);

  typedef enum logic [2:0] {
    S_IF = 3'd0, S_ID = 3'd1, S_EXE = 3'd2, S_MEM = 3'd3, S_WB = 3'd4, S_TRAP = 3'd7
  } state_t;

  typedef enum logic [3:0] {
    K_ILL, K_ALUR, K_ALUI, K_LUI, K_LOAD, K_STORE, K_BR, K_J, K_JAL, K_JR, K_JALR
  } kind_t;

  state_t           r_state;
  logic [1:0]       r_cause;
  logic [TMO_W-1:0] r_cnt;

  kind_t      w_kind;
  logic [3:0] w_alu;
  logic [1:0] w_ext;
  logic [2:0] w_br;
  logic [1:0] w_sz;
  logic       w_src;
  logic       w_tmo;

  always_comb begin
    w_kind = K_ILL;
    w_alu  = 4'd0;
    w_ext  = 2'd0;
    w_br   = 3'd0;
    w_sz   = 2'd0;
    case (op)
      6'h00: begin
        w_kind = K_ALUR;
        case (func)
          6'h21: w_alu = 4'd0;
          6'h23: w_alu = 4'd1;
          6'h2A: w_alu = 4'd2;
          6'h24: w_alu = 4'd3;
          6'h27: w_alu = 4'd4;
          6'h25: w_alu = 4'd5;
          6'h26: w_alu = 4'd6;
          6'h00: w_alu = 4'd7;
          6'h02: w_alu = 4'd8;
          6'h2B: w_alu = 4'd9;
          6'h04: w_alu = 4'd12;
          6'h03: w_alu = 4'd13;
          6'h07: w_alu = 4'd14;
          6'h06: w_alu = 4'd15;
          6'h08: w_kind = K_JR;
          6'h09: w_kind = K_JALR;
          default: w_kind = K_ILL;
        endcase
      end
      6'h01: begin
        if (rt == 5'd1) begin
          w_kind = K_BR;
          w_br   = 3'd3;
        end else if (rt == 5'd0) begin
          w_kind = K_BR;
          w_br   = 3'd4;
        end
      end
      6'h02: w_kind = K_J;
      6'h03: w_kind = K_JAL;
      6'h04: begin w_kind = K_BR;   w_br  = 3'd1; w_alu = 4'd1; end
      6'h05: begin w_kind = K_BR;   w_br  = 3'd2; w_alu = 4'd1; end
      6'h06: begin w_kind = K_BR;   w_br  = 3'd6; end
      6'h07: begin w_kind = K_BR;   w_br  = 3'd5; end
      6'h09: begin w_kind = K_ALUI; w_alu = 4'd0; w_ext = 2'd1; end
      6'h0A: begin w_kind = K_ALUI; w_alu = 4'd2; w_ext = 2'd1; end
      6'h0B: begin w_kind = K_ALUI; w_alu = 4'd9; w_ext = 2'd1; end
      6'h0C: begin w_kind = K_ALUI; w_alu = 4'd3; end
      6'h0D: begin w_kind = K_ALUI; w_alu = 4'd5; end
      6'h0E: begin w_kind = K_ALUI; w_alu = 4'd6; end
      6'h0F: begin w_kind = K_LUI;  w_ext = 2'd2; end
      6'h20: begin w_kind = K_LOAD;  w_ext = 2'd1; w_sz = 2'd1; end
      6'h23: begin w_kind = K_LOAD;  w_ext = 2'd1; w_sz = 2'd0; end
      6'h24: begin w_kind = K_LOAD;  w_ext = 2'd1; w_sz = 2'd2; end
      6'h28: begin w_kind = K_STORE; w_ext = 2'd1; w_sz = 2'd1; end
      6'h2B: begin w_kind = K_STORE; w_ext = 2'd1; w_sz = 2'd0; end
      default: w_kind = K_ILL;
    endcase
  end

  assign w_src = (w_kind == K_ALUI) || (w_kind == K_LUI) ||
                 (w_kind == K_LOAD) || (w_kind == K_STORE);

  // The counter may sit at MEM_TIMEOUT for one cycle: a ready arriving then is still a success.
  assign w_tmo = (MEM_TIMEOUT != 0) && (r_cnt == TMO_W'(MEM_TIMEOUT)) && !mem_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IF;
      r_cause <= 2'd0;
      r_cnt   <= '0;
    end else begin
      r_cnt <= '0;
      case (r_state)
        S_IF: begin
          if (mem_ready) begin
            r_state <= S_ID;
          end else if (w_tmo) begin
            r_state <= S_TRAP;
            r_cause <= 2'd2;
          end else begin
            r_cnt <= r_cnt + TMO_W'(1);
          end
        end
        S_ID: begin
          case (w_kind)
            K_ILL: begin
              r_state <= S_TRAP;
              r_cause <= 2'd1;
            end
            K_J, K_JAL, K_JR, K_JALR: r_state <= S_IF;
            default: r_state <= S_EXE;
          endcase
        end
        S_EXE: begin
          case (w_kind)
            K_BR:                  r_state <= S_IF;
            K_LOAD, K_STORE:       r_state <= S_MEM;
            K_ALUR, K_ALUI, K_LUI: r_state <= S_WB;
            default:               r_state <= S_IF;
          endcase
        end
        S_MEM: begin
          if (mem_ready) begin
            r_state <= (w_kind == K_STORE) ? S_IF : S_WB;
          end else if (w_tmo) begin
            r_state <= S_TRAP;
            r_cause <= 2'd2;
          end else begin
            r_cnt <= r_cnt + TMO_W'(1);
          end
        end
        S_WB:    r_state <= S_IF;
        default: r_state <= S_TRAP;
      endcase
    end
  end

  always_comb begin
    PCWr     = 1'b0;
    PCWrCond = 1'b0;
    IRWr     = 1'b0;
    RegDst   = 2'd0;
    RegWr    = 1'b0;
    ALUSrc   = 1'b0;
    MemRd    = 1'b0;
    MemWr    = 1'b0;
    IorD     = 1'b0;
    MemtoReg = 2'd0;
    ExtOp    = 2'd0;
    MemSz    = 2'd0;
    ALUctr   = '0;
    BrType   = 3'd0;
    Jump     = 2'd0;
    case (r_state)
      S_IF: begin
        MemRd = 1'b1;
        if (mem_ready) begin
          IRWr = 1'b1;
          PCWr = 1'b1;
        end
      end
      S_ID: begin
        case (w_kind)
          K_J: begin
            PCWr = 1'b1;
            Jump = 2'd1;
          end
          K_JAL: begin
            PCWr     = 1'b1;
            Jump     = 2'd1;
            RegWr    = 1'b1;
            RegDst   = 2'd2;
            MemtoReg = 2'd2;
          end
          K_JR: begin
            PCWr = 1'b1;
            Jump = 2'd2;
          end
          K_JALR: begin
            PCWr     = 1'b1;
            Jump     = 2'd2;
            RegWr    = 1'b1;
            RegDst   = 2'd1;
            MemtoReg = 2'd2;
          end
          default: ;
        endcase
      end
      S_EXE: begin
        ALUSrc = w_src;
        ExtOp  = w_ext;
        ALUctr = ALUCTR_W'(w_alu);
        if (w_kind == K_BR) begin
          PCWrCond = 1'b1;
          BrType   = w_br;
        end
      end
      S_MEM: begin
        IorD  = 1'b1;
        MemSz = w_sz;
        MemRd = (w_kind == K_LOAD);
        MemWr = (w_kind == K_STORE);
      end
      S_WB: begin
        RegWr    = 1'b1;
        RegDst   = (w_kind == K_ALUR) ? 2'd1 : 2'd0;
        MemtoReg = (w_kind == K_LOAD) ? 2'd1 : (w_kind == K_LUI) ? 2'd3 : 2'd0;
        ALUSrc   = w_src;
        ExtOp    = w_ext;
        ALUctr   = ALUCTR_W'(w_alu);
      end
      default: ;
    endcase
    if (rst) begin
      PCWr     = 1'b0;
      PCWrCond = 1'b0;
      IRWr     = 1'b0;
      RegWr    = 1'b0;
      MemRd    = 1'b0;
      MemWr    = 1'b0;
    end
  end

  assign state = r_state;
  assign cause = r_cause;

endmodule

// File: tb/tb_mc_ctrl.sv
// Bench for mc_ctrl: directed instruction sequences push expected per-cycle outputs into a queue;
// a negedge monitor pops and compares. Instance b runs with MEM_TIMEOUT=4.
module tb_mc_ctrl;

  typedef struct packed {
    logic       pcwr, pcwrcond, irwr;
    logic [1:0] regdst;
    logic       regwr, alusrc, memrd, memwr, iord;
    logic [1:0] memtoreg, extop, memsz;
    logic [4:0] aluctr;
    logic [2:0] brtype;
    logic [1:0] jump;
    logic [2:0] state;
    logic [1:0] cause;
  } ctl_t;

  typedef struct {
    logic        sel;
    ctl_t        e;
    logic [95:0] tag;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, rst_b, rdy_a, rdy_b;
  logic [5:0] op, func;
  logic [4:0] rt;

  logic       pcwr_a, pcwrc_a, irwr_a, regwr_a, alusrc_a, memrd_a, memwr_a, iord_a;
  logic [1:0] regdst_a, m2r_a, ext_a, sz_a, jump_a, cause_a;
  logic [4:0] alu_a;
  logic [2:0] br_a, state_a;
  logic       pcwr_b, pcwrc_b, irwr_b, regwr_b, alusrc_b, memrd_b, memwr_b, iord_b;
  logic [1:0] regdst_b, m2r_b, ext_b, sz_b, jump_b, cause_b;
  logic [4:0] alu_b;
  logic [2:0] br_b, state_b;

  mc_ctrl u_a (
    .clk(clk), .rst(rst_a), .op(op), .func(func), .rt(rt), .mem_ready(rdy_a),
    .PCWr(pcwr_a), .PCWrCond(pcwrc_a), .IRWr(irwr_a), .RegDst(regdst_a), .RegWr(regwr_a),
    .ALUSrc(alusrc_a), .MemRd(memrd_a), .MemWr(memwr_a), .IorD(iord_a), .MemtoReg(m2r_a),
    .ExtOp(ext_a), .MemSz(sz_a), .ALUctr(alu_a), .BrType(br_a), .Jump(jump_a),
    .state(state_a), .cause(cause_a)
  );

  mc_ctrl #(.MEM_TIMEOUT(4), .TMO_W(3)) u_b (
    .clk(clk), .rst(rst_b), .op(op), .func(func), .rt(rt), .mem_ready(rdy_b),
    .PCWr(pcwr_b), .PCWrCond(pcwrc_b), .IRWr(irwr_b), .RegDst(regdst_b), .RegWr(regwr_b),
    .ALUSrc(alusrc_b), .MemRd(memrd_b), .MemWr(memwr_b), .IorD(iord_b), .MemtoReg(m2r_b),
    .ExtOp(ext_b), .MemSz(sz_b), .ALUctr(alu_b), .BrType(br_b), .Jump(jump_b),
    .state(state_b), .cause(cause_b)
  );

  ctl_t obs_a, obs_b;
  assign obs_a = {pcwr_a, pcwrc_a, irwr_a, regdst_a, regwr_a, alusrc_a, memrd_a, memwr_a, iord_a,
                  m2r_a, ext_a, sz_a, alu_a, br_a, jump_a, state_a, cause_a};
  assign obs_b = {pcwr_b, pcwrc_b, irwr_b, regdst_b, regwr_b, alusrc_b, memrd_b, memwr_b, iord_b,
                  m2r_b, ext_b, sz_b, alu_b, br_b, jump_b, state_b, cause_b};

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t x;
      ctl_t got;
      x = q.pop_front();
      got = x.sel ? obs_b : obs_a;
      n_vec++;
      if (got !== x.e) begin
        n_err++;
        $display("FAIL %0s: got %h (state %0d cause %0d) expected %h (state %0d cause %0d)",
                 x.tag, got, got.state, got.cause, x.e, x.e.state, x.e.cause);
      end
    end
  end

  function automatic ctl_t st(input logic [2:0] s);
    ctl_t e;
    e = '0;
    e.state = s;
    return e;
  endfunction

  function automatic ctl_t f_if(input bit rdy);
    ctl_t e;
    e = st(3'd0);
    e.memrd = 1'b1;
    e.irwr  = rdy;
    e.pcwr  = rdy;
    return e;
  endfunction

  task automatic cyc(input bit sel, input ctl_t e, input logic [95:0] tag);
    exp_t x;
    x.sel = sel;
    x.e   = e;
    x.tag = tag;
    q.push_back(x);
    @(posedge clk);
    #1;
  endtask

  // ALU instruction with zero wait states: IF, ID, EXE, WB.
  task automatic alu_instr(input logic [5:0] o, input logic [5:0] f, input bit rtype,
                           input bit src, input logic [1:0] ext, input logic [4:0] alu);
    ctl_t e;
    op = o; func = f; rdy_a = 1'b1;
    cyc(0, f_if(1), "alu_if");
    cyc(0, st(3'd1), "alu_id");
    e = st(3'd2); e.alusrc = src; e.extop = ext; e.aluctr = alu;
    cyc(0, e, "alu_exe");
    e.state = 3'd4; e.regwr = 1'b1; e.regdst = rtype ? 2'd1 : 2'd0;
    cyc(0, e, "alu_wb");
  endtask

  initial begin
    ctl_t e;
    rst_a = 1'b1; rst_b = 1'b1; rdy_a = 1'b0; rdy_b = 1'b0;
    op = 6'd0; func = 6'd0; rt = 5'd0;
    @(posedge clk);
    #1;
    cyc(0, st(3'd0), "reset");
    rst_a = 1'b0;

    alu_instr(6'h00, 6'h21, 1'b1, 1'b0, 2'd0, 5'd0);   // addu
    alu_instr(6'h00, 6'h07, 1'b1, 1'b0, 2'd0, 5'd14);  // srav
    alu_instr(6'h0D, 6'h00, 1'b0, 1'b1, 2'd0, 5'd5);   // ori
    alu_instr(6'h0A, 6'h00, 1'b0, 1'b1, 2'd1, 5'd2);   // slti

    // lw with three wait cycles in MEM
    op = 6'h23; rdy_a = 1'b1;
    cyc(0, f_if(1), "lw_if");
    cyc(0, st(3'd1), "lw_id");
    e = st(3'd2); e.alusrc = 1'b1; e.extop = 2'd1;
    cyc(0, e, "lw_exe");
    e = st(3'd3); e.memrd = 1'b1; e.iord = 1'b1;
    rdy_a = 1'b0;
    for (int i = 0; i < 3; i++) cyc(0, e, "lw_memwait");
    rdy_a = 1'b1;
    cyc(0, e, "lw_memdone");
    e = st(3'd4); e.regwr = 1'b1; e.memtoreg = 2'd1; e.alusrc = 1'b1; e.extop = 2'd1;
    cyc(0, e, "lw_wb");

    // sb, zero wait
    op = 6'h28;
    cyc(0, f_if(1), "sb_if");
    cyc(0, st(3'd1), "sb_id");
    e = st(3'd2); e.alusrc = 1'b1; e.extop = 2'd1;
    cyc(0, e, "sb_exe");
    e = st(3'd3); e.memwr = 1'b1; e.iord = 1'b1; e.memsz = 2'd1;
    cyc(0, e, "sb_mem");

    // bgez then beq
    op = 6'h01; rt = 5'd1;
    cyc(0, f_if(1), "bgez_if");
    cyc(0, st(3'd1), "bgez_id");
    e = st(3'd2); e.pcwrcond = 1'b1; e.brtype = 3'd3;
    cyc(0, e, "bgez_exe");
    op = 6'h04; rt = 5'd0;
    cyc(0, f_if(1), "beq_if");
    cyc(0, st(3'd1), "beq_id");
    e = st(3'd2); e.pcwrcond = 1'b1; e.brtype = 3'd1; e.aluctr = 5'd1;
    cyc(0, e, "beq_exe");

    // jal, jr
    op = 6'h03;
    cyc(0, f_if(1), "jal_if");
    e = st(3'd1); e.pcwr = 1'b1; e.jump = 2'd1; e.regwr = 1'b1; e.regdst = 2'd2; e.memtoreg = 2'd2;
    cyc(0, e, "jal_id");
    op = 6'h00; func = 6'h08;
    cyc(0, f_if(1), "jr_if");
    e = st(3'd1); e.pcwr = 1'b1; e.jump = 2'd2;
    cyc(0, e, "jr_id");

    // sw aborted by reset while waiting in MEM
    op = 6'h2B;
    cyc(0, f_if(1), "sw_if");
    cyc(0, st(3'd1), "sw_id");
    e = st(3'd2); e.alusrc = 1'b1; e.extop = 2'd1;
    cyc(0, e, "sw_exe");
    rdy_a = 1'b0;
    e = st(3'd3); e.memwr = 1'b1; e.iord = 1'b1;
    cyc(0, e, "sw_memwait");
    rst_a = 1'b1;
    e = st(3'd3); e.iord = 1'b1;
    cyc(0, e, "rst_in_mem");
    cyc(0, st(3'd0), "rst_hold");
    rst_a = 1'b0;
    cyc(0, f_if(0), "rst_release");

    // illegal opcode traps; ready pulses are ignored in TRAP
    op = 6'h3F; rdy_a = 1'b1;
    cyc(0, f_if(1), "ill_if");
    cyc(0, st(3'd1), "ill_id");
    e = st(3'd7); e.cause = 2'd1;
    for (int i = 0; i < 3; i++) begin
      rdy_a = (i != 1);
      cyc(0, e, "trap_hold");
    end
    rst_a = 1'b1;
    cyc(0, e, "trap_rst");
    rst_a = 1'b0; rdy_a = 1'b0;
    cyc(0, f_if(0), "trap_exit");

    // timeout instance: ready stuck low in IF
    op = 6'h00; func = 6'h21;
    rst_b = 1'b0; rdy_b = 1'b0;
    for (int i = 0; i < 5; i++) cyc(1, f_if(0), "tmo_wait");
    e = st(3'd7); e.cause = 2'd2;
    cyc(1, e, "tmo_trap");
    rst_b = 1'b1;
    cyc(1, e, "tmo_rst");
    rst_b = 1'b0;
    for (int i = 0; i < 4; i++) cyc(1, f_if(0), "tmo2_wait");
    rdy_b = 1'b1;
    cyc(1, f_if(1), "tmo2_limit");
    cyc(1, st(3'd1), "tmo2_id");

    @(posedge clk);
    @(posedge clk);
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
